// File: rtl/ycr_dm_dmi_resp_pkg.sv
// Shared DM definitions: DMI register addresses, abstract-command error codes and FSM states.
package ycr_dm_dmi_resp_pkg;

    localparam logic [6:0] ADDR_DATA0        = 7'h04;
    localparam logic [6:0] ADDR_DATA1        = 7'h05;
    localparam logic [6:0] ADDR_DMCONTROL    = 7'h10;
    localparam logic [6:0] ADDR_DMSTATUS     = 7'h11;
    localparam logic [6:0] ADDR_HARTINFO     = 7'h12;
    localparam logic [6:0] ADDR_ABSTRACTCS   = 7'h16;
    localparam logic [6:0] ADDR_COMMAND      = 7'h17;
    localparam logic [6:0] ADDR_ABSTRACTAUTO = 7'h18;

    typedef enum logic [2:0] {
        CMDERR_NONE       = 3'd0,
        CMDERR_BUSY       = 3'd1,
        CMDERR_NOTSUP     = 3'd2,
        CMDERR_EXC        = 3'd3,
        CMDERR_HALTRESUME = 3'd4
    } cmderr_e;

    typedef enum logic [1:0] {
        ABS_IDLE = 2'd0,
        ABS_REQ  = 2'd1,
        ABS_EXEC = 2'd2
    } abs_state_e;

    // dmstatus: version 2, always authenticated, single-hart all/any pairs.
    function automatic logic [31:0] dmstatus_word(input logic halted, input logic resumeack);
        logic [31:0] w;
        w        = '0;
        w[3:0]   = 4'd2;
        w[7]     = 1'b1;
        w[9:8]   = {2{halted}};
        w[11:10] = {2{~halted}};
        w[17:16] = {2{resumeack}};
        return w;
    endfunction

endpackage

// File: rtl/ycr_dm_dmi_resp_if.sv
// DMI request/response bundle between the DMI bridge (master) and the DM responder (slave).
interface ycr_dm_dmi_resp_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              resp;
    logic [DATA_W-1:0] rdata;

    modport master (output req, wr, addr, wdata, input resp, rdata);
    modport slave  (input req, wr, addr, wdata, output resp, rdata);
endinterface

// File: rtl/ycr_dm_dmi_resp_abs_cmd_fsm.sv
// Abstract-command sequencer: IDLE -> REQ (wait ack) -> EXEC (wait done), plus the sticky cmderr field.
module ycr_dm_dmi_resp_abs_cmd_fsm
    import ycr_dm_dmi_resp_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       halted_i,
    input  logic       cmd_wr_i,
    input  logic       acc_i,
    input  logic       cs_wr_i,
    input  logic [2:0] cs_w1c_i,
    input  logic       auto_trig_i,
    input  logic       ack_i,
    input  logic       done_i,
    input  logic [2:0] err_i,
    output logic       busy_o,
    output logic       exec_o,
    output logic       cmd_latch_o,
    output logic       cmd_req_o,
    output cmderr_e    cmderr_o
);
    abs_state_e state_q, state_d;
    cmderr_e    cmderr_q, cmderr_d;
    logic       finish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ABS_IDLE;
            cmderr_q <= CMDERR_NONE;
        end else begin
            state_q  <= state_d;
            cmderr_q <= cmderr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmderr_d    = cmderr_q;
        cmd_latch_o = 1'b0;
        finish      = 1'b0;
        case (state_q)
            ABS_IDLE: begin
                if (cmd_wr_i) begin
                    if (cmderr_q == CMDERR_NONE) begin
                        if (!halted_i) begin
                            cmderr_d = CMDERR_HALTRESUME;
                        end else begin
                            state_d     = ABS_REQ;
                            cmd_latch_o = 1'b1;
                        end
                    end
                end else if (auto_trig_i && cmderr_q == CMDERR_NONE) begin
                    state_d = ABS_REQ;
                end else if (cs_wr_i && cmderr_q != CMDERR_NONE
                             && (cmderr_q & ~cs_w1c_i) == 3'b000) begin
                    // Clearing only when every set bit is written 1 keeps cmderr 0<->nonzero only.
                    cmderr_d = CMDERR_NONE;
                end
            end
            ABS_REQ: begin
                if (ack_i) begin
                    state_d = done_i ? ABS_IDLE : ABS_EXEC;
                    finish  = done_i;
                end
            end
            ABS_EXEC: begin
                if (done_i) begin
                    state_d = ABS_IDLE;
                    finish  = 1'b1;
                end
            end
            default: state_d = ABS_IDLE;
        endcase

        if (finish && cmderr_q == CMDERR_NONE) begin
            cmderr_d = cmderr_e'(err_i);
        end
        if (state_q != ABS_IDLE && (cmd_wr_i || acc_i) && cmderr_d == CMDERR_NONE) begin
            cmderr_d = CMDERR_BUSY;
        end
        if (clr_i) begin
            state_d     = ABS_IDLE;
            cmderr_d    = CMDERR_NONE;
            cmd_latch_o = 1'b0;
        end
    end

    assign busy_o    = (state_q != ABS_IDLE);
    assign exec_o    = (state_q == ABS_EXEC);
    assign cmd_req_o = (state_q == ABS_REQ);
    assign cmderr_o  = cmderr_q;

endmodule

// File: rtl/ycr_dm_dmi_resp.sv
// DM-side DMI responder: DM register file, same-cycle read mux and halt/resume/abstract-command handshakes.
// Optional YCR_DM_AUTOEXEC_EN enables abstractauto.autoexecdata re-issue on data0 accesses.
module ycr_dm_dmi_resp
    import ycr_dm_dmi_resp_pkg::*;
#(
    parameter int          DMI_ADDR_W   = 7,
    parameter int          DMI_DATA_W   = 32,
    parameter logic [31:0] HARTINFO_VAL = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ycr_dm_dmi_resp_if.slave      dmi,
    output logic                  dm2hart_haltreq_o,
    output logic                  dm2hart_resumereq_o,
    output logic                  dm2hart_ndmreset_o,
    output logic                  dm_active_o,
    input  logic                  hart2dm_halted_i,
    input  logic                  hart2dm_resumeack_i,
    output logic                  dm2hart_cmd_req_o,
    output logic [DMI_DATA_W-1:0] dm2hart_cmd_o,
    input  logic                  hart2dm_cmd_ack_i,
    input  logic                  hart2dm_cmd_done_i,
    input  logic [2:0]            hart2dm_cmd_err_i,
    input  logic                  hart2dm_data0_we_i,
    input  logic [DMI_DATA_W-1:0] hart2dm_data0_i
);
    localparam logic [DMI_ADDR_W-1:0] A_DATA0   = DMI_ADDR_W'(ADDR_DATA0);
    localparam logic [DMI_ADDR_W-1:0] A_DATA1   = DMI_ADDR_W'(ADDR_DATA1);
    localparam logic [DMI_ADDR_W-1:0] A_DMCTRL  = DMI_ADDR_W'(ADDR_DMCONTROL);
    localparam logic [DMI_ADDR_W-1:0] A_DMSTAT  = DMI_ADDR_W'(ADDR_DMSTATUS);
    localparam logic [DMI_ADDR_W-1:0] A_HARTINF = DMI_ADDR_W'(ADDR_HARTINFO);
    localparam logic [DMI_ADDR_W-1:0] A_ABSCS   = DMI_ADDR_W'(ADDR_ABSTRACTCS);
    localparam logic [DMI_ADDR_W-1:0] A_COMMAND = DMI_ADDR_W'(ADDR_COMMAND);
    localparam logic [DMI_ADDR_W-1:0] A_ABSAUTO = DMI_ADDR_W'(ADDR_ABSTRACTAUTO);

    logic                  dmactive_q, dmactive_d, haltreq_q, haltreq_d, ndmreset_q, ndmreset_d;
    logic                  resumereq_q, resumereq_d, ack_sticky_q, ack_sticky_d;
    logic [DMI_DATA_W-1:0] data0_q, data0_d, data1_q, data1_d, command_q, command_d;
    logic                  rd_req, wr_req, dmc_wr, clr, busy, exec, cmd_latch, auto_trig;
    logic [DMI_DATA_W-1:0] rdata_mux;
    cmderr_e               cmderr;

    assign rd_req = dmi.req & ~dmi.wr;
    assign wr_req = dmi.req & dmi.wr;
    assign dmc_wr = wr_req && (dmi.addr == A_DMCTRL);
    // Writing dmactive=0, or sitting inactive, holds everything else at reset.
    assign clr    = ~dmactive_q | (dmc_wr & ~dmi.wdata[0]);

`ifdef YCR_DM_AUTOEXEC_EN
    logic autoexec_q, autoexec_d;
    assign auto_trig = autoexec_q & dmi.req & (dmi.addr == A_DATA0);
`else
    assign auto_trig = 1'b0;
`endif

    ycr_dm_dmi_resp_abs_cmd_fsm u_abs_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (clr),
        .halted_i    (hart2dm_halted_i),
        .cmd_wr_i    (wr_req && (dmi.addr == A_COMMAND)),
        .acc_i       ((dmi.req && (dmi.addr == A_DATA0 || dmi.addr == A_DATA1))
                      || (wr_req && (dmi.addr == A_ABSCS))),
        .cs_wr_i     (wr_req && (dmi.addr == A_ABSCS)),
        .cs_w1c_i    (dmi.wdata[10:8]),
        .auto_trig_i (auto_trig),
        .ack_i       (hart2dm_cmd_ack_i),
        .done_i      (hart2dm_cmd_done_i),
        .err_i       (hart2dm_cmd_err_i),
        .busy_o      (busy),
        .exec_o      (exec),
        .cmd_latch_o (cmd_latch),
        .cmd_req_o   (dm2hart_cmd_req_o),
        .cmderr_o    (cmderr)
    );

    always_comb begin
        dmactive_d   = dmactive_q;
        haltreq_d    = haltreq_q;
        ndmreset_d   = ndmreset_q;
        resumereq_d  = resumereq_q;
        ack_sticky_d = ack_sticky_q;
        data0_d      = data0_q;
        data1_d      = data1_q;
        command_d    = command_q;
`ifdef YCR_DM_AUTOEXEC_EN
        autoexec_d   = autoexec_q;
        if (wr_req && dmi.addr == A_ABSAUTO) autoexec_d = dmi.wdata[0];
`endif
        if (dmc_wr) begin
            dmactive_d = dmi.wdata[0];
            haltreq_d  = dmi.wdata[31];
            ndmreset_d = dmi.wdata[1];
        end
        if (resumereq_q && hart2dm_resumeack_i) begin
            resumereq_d  = 1'b0;
            ack_sticky_d = 1'b1;
        end
        if (dmc_wr && dmi.wdata[30] && !dmi.wdata[31] && hart2dm_halted_i) begin
            resumereq_d  = 1'b1;
            ack_sticky_d = 1'b0;
        end
        if (wr_req && dmi.addr == A_DATA0 && !busy)  data0_d = dmi.wdata;
        else if (exec && hart2dm_data0_we_i)         data0_d = hart2dm_data0_i;
        if (wr_req && dmi.addr == A_DATA1 && !busy)  data1_d = dmi.wdata;
        if (cmd_latch)                               command_d = dmi.wdata;
        if (clr) begin
            haltreq_d    = 1'b0;
            ndmreset_d   = 1'b0;
            resumereq_d  = 1'b0;
            ack_sticky_d = 1'b0;
            data0_d      = '0;
            data1_d      = '0;
            command_d    = '0;
`ifdef YCR_DM_AUTOEXEC_EN
            autoexec_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmactive_q   <= 1'b0;
            haltreq_q    <= 1'b0;
            ndmreset_q   <= 1'b0;
            resumereq_q  <= 1'b0;
            ack_sticky_q <= 1'b0;
            data0_q      <= '0;
            data1_q      <= '0;
            command_q    <= '0;
`ifdef YCR_DM_AUTOEXEC_EN
            autoexec_q   <= 1'b0;
`endif
        end else begin
            dmactive_q   <= dmactive_d;
            haltreq_q    <= haltreq_d;
            ndmreset_q   <= ndmreset_d;
            resumereq_q  <= resumereq_d;
            ack_sticky_q <= ack_sticky_d;
            data0_q      <= data0_d;
            data1_q      <= data1_d;
            command_q    <= command_d;
`ifdef YCR_DM_AUTOEXEC_EN
            autoexec_q   <= autoexec_d;
`endif
        end
    end

    always_comb begin
        rdata_mux = '0;
        case (dmi.addr)
            A_DATA0:   rdata_mux = busy ? '0 : data0_q;
            A_DATA1:   rdata_mux = busy ? '0 : data1_q;
            A_DMCTRL:  rdata_mux = DMI_DATA_W'({haltreq_q, 29'b0, ndmreset_q, dmactive_q});
            A_DMSTAT:  rdata_mux = DMI_DATA_W'(dmstatus_word(hart2dm_halted_i, ack_sticky_q));
            A_HARTINF: rdata_mux = DMI_DATA_W'(HARTINFO_VAL);
            A_ABSCS:   rdata_mux = DMI_DATA_W'({19'b0, busy, 1'b0, cmderr, 4'b0, 4'd2});
`ifdef YCR_DM_AUTOEXEC_EN
            A_ABSAUTO: rdata_mux = DMI_DATA_W'(autoexec_q);
`endif
            default:   rdata_mux = '0;
        endcase
    end

    assign dmi.resp            = dmi.req;
    assign dmi.rdata           = rd_req ? rdata_mux : '0;
    assign dm2hart_haltreq_o   = haltreq_q;
    assign dm2hart_resumereq_o = resumereq_q;
    assign dm2hart_ndmreset_o  = ndmreset_q;
    assign dm_active_o         = dmactive_q;
    assign dm2hart_cmd_o       = command_q;

endmodule
